// File: rtl/traffic_analyzer_gmii_pkg.sv
// Shared definitions for the GMII traffic analyzer and its CRC helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package traffic_analyzer_gmii_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        DATA,
        EOF,
        DROP
    } state_t;

    typedef enum logic [2:0] {
        STAT_GOOD     = 3'd0,
        STAT_CRC      = 3'd1,
        STAT_RUNT     = 3'd2,
        STAT_OVERSIZE = 3'd3,
        STAT_RX_ERR   = 3'd4
    } status_t;

    localparam logic [7:0]  GMII_PREAMBLE = 8'h55;
    localparam logic [7:0]  GMII_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
    // Residue and polynomial are given MSB-first; the shift register runs
    // LSB-first (reflected), so both are bit-reversed where they are used.
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
    localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gmii_crc32_d8.sv
// Next-state of a reflected CRC-32 register after absorbing one byte, LSB first.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to load crc_out.
// Ports: crc_in current register, data byte to absorb, crc_out updated register.
module gmii_crc32_d8
    import traffic_analyzer_gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/traffic_analyzer_gmii.sv
// GMII receive analyzer: delineates frames by preamble/SFD, checks FCS, classifies and counts them.
// Latency: frame_done rises on the 2nd clk edge after the edge that samples gmii_dv low.
// Backpressure: none; the GMII stream cannot be stalled and every byte is consumed.
// Ports: gmii_d/dv/er receive stream; sec/nsec timebase; enable gates new frames; clear zeroes
//        statistics; class counters, good_bytes and ifg_* statistics; frame_* per-frame report.
module traffic_analyzer_gmii
    import traffic_analyzer_gmii_pkg::*;
#(
    parameter int C_MIN_FRAME = 64,
    parameter int C_MAX_FRAME = 1518,
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             gmii_d,
    input  logic                   gmii_dv,
    input  logic                   gmii_er,
    input  logic [47:0]            sec,
    input  logic [29:0]            nsec,
    input  logic                   enable,
    input  logic                   clear,
    output logic [C_CNT_WIDTH-1:0] good_frames,
    output logic [C_CNT_WIDTH-1:0] crc_err_frames,
    output logic [C_CNT_WIDTH-1:0] runt_frames,
    output logic [C_CNT_WIDTH-1:0] oversize_frames,
    output logic [C_CNT_WIDTH-1:0] rx_err_frames,
    output logic [C_CNT_WIDTH-1:0] bad_preamble,
    output logic [47:0]            good_bytes,
    output logic [C_CNT_WIDTH-1:0] ifg_last,
    output logic [C_CNT_WIDTH-1:0] ifg_min,
    output logic [C_CNT_WIDTH-1:0] ifg_max,
    output logic                   frame_done,
    output logic [2:0]             frame_status,
    output logic [15:0]            frame_len,
    output logic [47:0]            frame_sec,
    output logic [29:0]            frame_nsec
);

    localparam logic [15:0]            MIN_LEN = 16'(C_MIN_FRAME);
    localparam logic [15:0]            MAX_LEN = 16'(C_MAX_FRAME);
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = C_CNT_WIDTH'(1);
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;

    // Input capture stage
    logic [7:0] d_r;
    logic       dv_r;
    logic       er_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            d_r  <= '0;
            dv_r <= 1'b0;
            er_r <= 1'b0;
        end else begin
            d_r  <= gmii_d;
            dv_r <= gmii_dv;
            er_r <= gmii_er;
        end
    end

    state_t      state, state_nxt;
    logic [31:0] crc;
    logic [31:0] crc_next;
    logic [15:0] len;
    logic        er_flag;
    logic [47:0] ts_sec;
    logic [29:0] ts_nsec;
    logic [C_CNT_WIDTH-1:0] gap_cnt;
    logic        gap_vld;

    logic        start_data;
    logic        bad_pre_inc;
    logic        ifg_commit;
    status_t     eof_status;

    gmii_crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (d_r),
        .crc_out (crc_next)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A bare SFD straight out of IDLE is a zero-length preamble and is accepted.
    always_comb begin
        state_nxt   = state;
        start_data  = 1'b0;
        bad_pre_inc = 1'b0;
        case (state)
            IDLE: begin
                if (dv_r) begin
                    if (!enable) begin
                        state_nxt = DROP;
                    end else if (d_r == GMII_PREAMBLE) begin
                        state_nxt = PREAMBLE;
                    end else if (d_r == GMII_SFD) begin
                        state_nxt  = DATA;
                        start_data = 1'b1;
                    end else begin
                        state_nxt   = DROP;
                        bad_pre_inc = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!dv_r) begin
                    state_nxt   = IDLE;
                    bad_pre_inc = 1'b1;
                end else if (d_r == GMII_SFD) begin
                    state_nxt  = DATA;
                    start_data = 1'b1;
                end else if (d_r != GMII_PREAMBLE) begin
                    state_nxt   = DROP;
                    bad_pre_inc = 1'b1;
                end
            end
            DATA: begin
                if (!dv_r) begin
                    state_nxt = EOF;
                end
            end
            EOF: begin
                state_nxt = IDLE;
            end
            DROP: begin
                if (!dv_r) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Classification with error precedence: rx error, runt, oversize, FCS.
    always_comb begin
        eof_status = STAT_GOOD;
        if (er_flag) begin
            eof_status = STAT_RX_ERR;
        end else if (len < MIN_LEN) begin
            eof_status = STAT_RUNT;
        end else if (len > MAX_LEN) begin
            eof_status = STAT_OVERSIZE;
        end else if (bitrev32(crc) != CRC32_RESIDUE) begin
            eof_status = STAT_CRC;
        end
    end

    // Per-frame accumulation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc     <= CRC32_INIT;
            len     <= '0;
            er_flag <= 1'b0;
            ts_sec  <= '0;
            ts_nsec <= '0;
        end else if (start_data) begin
            crc     <= CRC32_INIT;
            len     <= '0;
            er_flag <= 1'b0;
            ts_sec  <= sec;
            ts_nsec <= nsec;
        end else if (state == DATA && dv_r) begin
            crc     <= crc_next;
            len     <= (len == 16'hFFFF) ? len : len + 16'd1;
            er_flag <= er_flag | er_r;
        end
    end

    // Per-frame report
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_done   <= 1'b0;
            frame_status <= '0;
            frame_len    <= '0;
            frame_sec    <= '0;
            frame_nsec   <= '0;
        end else begin
            frame_done <= (state == EOF);
            if (state == EOF) begin
                frame_status <= eof_status;
                frame_len    <= len;
                frame_sec    <= ts_sec;
                frame_nsec   <= ts_nsec;
            end
        end
    end

    // Gap counter restarts on every byte and counts idle cycles after it;
    // it is only meaningful once a frame has reached EOF since the last commit.
    assign ifg_commit = (state == IDLE) && dv_r && gap_vld;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gap_cnt <= '0;
            gap_vld <= 1'b0;
        end else begin
            if (dv_r) begin
                gap_cnt <= '0;
            end else if (gap_cnt != CNT_MAX) begin
                gap_cnt <= gap_cnt + CNT_ONE;
            end
            if (clear) begin
                gap_vld <= 1'b0;
            end else if (state == EOF) begin
                gap_vld <= 1'b1;
            end else if (ifg_commit) begin
                gap_vld <= 1'b0;
            end
        end
    end

    // Statistics; clear takes priority over any same-cycle update.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            good_frames     <= '0;
            crc_err_frames  <= '0;
            runt_frames     <= '0;
            oversize_frames <= '0;
            rx_err_frames   <= '0;
            bad_preamble    <= '0;
            good_bytes      <= '0;
            ifg_last        <= '0;
            ifg_min         <= CNT_MAX;
            ifg_max         <= '0;
        end else if (clear) begin
            good_frames     <= '0;
            crc_err_frames  <= '0;
            runt_frames     <= '0;
            oversize_frames <= '0;
            rx_err_frames   <= '0;
            bad_preamble    <= '0;
            good_bytes      <= '0;
            ifg_last        <= '0;
            ifg_min         <= CNT_MAX;
            ifg_max         <= '0;
        end else begin
            if (state == EOF) begin
                case (eof_status)
                    STAT_GOOD: begin
                        good_frames <= good_frames + CNT_ONE;
                        good_bytes  <= good_bytes + {32'd0, len};
                    end
                    STAT_CRC:      crc_err_frames  <= crc_err_frames + CNT_ONE;
                    STAT_RUNT:     runt_frames     <= runt_frames + CNT_ONE;
                    STAT_OVERSIZE: oversize_frames <= oversize_frames + CNT_ONE;
                    STAT_RX_ERR:   rx_err_frames   <= rx_err_frames + CNT_ONE;
                    default: ;
                endcase
            end
            if (bad_pre_inc) begin
                bad_preamble <= bad_preamble + CNT_ONE;
            end
            if (ifg_commit) begin
                ifg_last <= gap_cnt;
                if (gap_cnt < ifg_min) begin
                    ifg_min <= gap_cnt;
                end
                if (gap_cnt > ifg_max) begin
                    ifg_max <= gap_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_analyzer_gmii.sv
// Self-checking bench for traffic_analyzer_gmii: directed frames, a frame-level reference model
// and a per-cycle checker of every frame_done report.
module tb_traffic_analyzer_gmii;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  gmii_d;
    logic        gmii_dv;
    logic        gmii_er;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        enable;
    logic        clear;
    logic [31:0] good_frames, crc_err_frames, runt_frames, oversize_frames, rx_err_frames, bad_preamble;
    logic [47:0] good_bytes;
    logic [31:0] ifg_last, ifg_min, ifg_max;
    logic        frame_done;
    logic [2:0]  frame_status;
    logic [15:0] frame_len;
    logic [47:0] frame_sec;
    logic [29:0] frame_nsec;

    always #5 clk = ~clk;

    traffic_analyzer_gmii #(
        .C_MIN_FRAME (64),
        .C_MAX_FRAME (1518),
        .C_CNT_WIDTH (32)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .gmii_d          (gmii_d),
        .gmii_dv         (gmii_dv),
        .gmii_er         (gmii_er),
        .sec             (sec),
        .nsec            (nsec),
        .enable          (enable),
        .clear           (clear),
        .good_frames     (good_frames),
        .crc_err_frames  (crc_err_frames),
        .runt_frames     (runt_frames),
        .oversize_frames (oversize_frames),
        .rx_err_frames   (rx_err_frames),
        .bad_preamble    (bad_preamble),
        .good_bytes      (good_bytes),
        .ifg_last        (ifg_last),
        .ifg_min         (ifg_min),
        .ifg_max         (ifg_max),
        .frame_done      (frame_done),
        .frame_status    (frame_status),
        .frame_len       (frame_len),
        .frame_sec       (frame_sec),
        .frame_nsec      (frame_nsec)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          status;
        int          len;
        logic [47:0] fsec;
        logic [29:0] fnsec;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  fb [0:2047];
    logic [31:0] m_good, m_crc, m_runt, m_over, m_rxerr, m_bad;
    logic [47:0] m_bytes;
    logic [31:0] m_ifg_last, m_ifg_min, m_ifg_max;
    bit          m_gap_vld;
    int          m_idle;
    int          ts_n = 0;

    task automatic model_zero();
        m_good = 0; m_crc = 0; m_runt = 0; m_over = 0; m_rxerr = 0; m_bad = 0;
        m_bytes = 0;
        m_ifg_last = 0; m_ifg_min = 32'hFFFF_FFFF; m_ifg_max = 0;
        m_gap_vld = 0;
    endtask

    // Standard Ethernet CRC-32 (as transmitted in the FCS) over fb[0..n-1].
    function automatic logic [31:0] crc32_of(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, fb[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build(input int len, input bit bad_fcs);
        logic [31:0] c;
        for (int i = 0; i < len - 4; i++) fb[i] = 8'(i * 13 + 5);
        c = crc32_of(len - 4);
        fb[len-4] = c[7:0];
        fb[len-3] = c[15:8];
        fb[len-2] = c[23:16];
        fb[len-1] = c[31:24];
        if (bad_fcs) fb[len-1] = fb[len-1] ^ 8'h01;
    endtask

    function automatic int classify(input int len, input int er_at);
        if (er_at >= 0 && er_at < len) return 4;
        if (len < 64) return 2;
        if (len > 1518) return 3;
        if ({fb[len-1], fb[len-2], fb[len-3], fb[len-4]} != crc32_of(len - 4)) return 1;
        return 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [7:0] d, input logic v, input logic e);
        gmii_d  = d;
        gmii_dv = v;
        gmii_er = e;
        @(posedge clk);
        #1;
        if (v) m_idle = 0;
        else m_idle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, (i % 3) == 0);
    endtask

    // Any frame start consumes a pending gap measurement.
    task automatic frame_start_model();
        if (m_gap_vld) begin
            m_ifg_last = 32'(m_idle);
            if (32'(m_idle) < m_ifg_min) m_ifg_min = 32'(m_idle);
            if (32'(m_idle) > m_ifg_max) m_ifg_max = 32'(m_idle);
            m_gap_vld = 0;
        end
    endtask

    task automatic send_frame(input int len, input bit bad_fcs, input int er_at);
        int   st;
        bit   en;
        exp_t e;
        ts_n++;
        sec  = 48'h0000_00AB_0000 + 48'(ts_n);
        nsec = 30'(ts_n * 1000 + 7);
        en   = enable;
        build(len, bad_fcs);
        st = classify(len, er_at);
        frame_start_model();
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) drive(fb[i], 1'b1, i == er_at);
        if (en) begin
            e.status = st;
            e.len    = len;
            e.fsec   = sec;
            e.fnsec  = nsec;
            e.due    = cyc + 3;
            exp_q.push_back(e);
            m_gap_vld = 1;
            case (st)
                0: begin m_good++; m_bytes += 48'(len); end
                1: m_crc++;
                2: m_runt++;
                3: m_over++;
                default: m_rxerr++;
            endcase
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        model_zero();
        drive(8'h00, 1'b0, 1'b0);
        clear = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_good"},     good_frames,     m_good);
        check({tag, "_crc"},      crc_err_frames,  m_crc);
        check({tag, "_runt"},     runt_frames,     m_runt);
        check({tag, "_over"},     oversize_frames, m_over);
        check({tag, "_rxerr"},    rx_err_frames,   m_rxerr);
        check({tag, "_badpre"},   bad_preamble,    m_bad);
        check({tag, "_bytes"},    good_bytes,      m_bytes);
        check({tag, "_ifg_last"}, ifg_last,        m_ifg_last);
        check({tag, "_ifg_min"},  ifg_min,         m_ifg_min);
        check({tag, "_ifg_max"},  ifg_max,         m_ifg_max);
        check({tag, "_pending"},  64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && frame_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_done", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("fd_status",  frame_status, 64'(e.status));
                    check("fd_len",     frame_len,    64'(e.len));
                    check("fd_sec",     frame_sec,    e.fsec);
                    check("fd_nsec",    frame_nsec,   e.fnsec);
                    check("fd_latency", 64'(cyc),     64'(e.due));
                    check("fd_good",    good_frames,    m_good);
                    check("fd_crc",     crc_err_frames, m_crc);
                    check("fd_runt",    runt_frames,    m_runt);
                    check("fd_over",    oversize_frames, m_over);
                    check("fd_rxerr",   rx_err_frames,  m_rxerr);
                    check("fd_bytes",   good_bytes,     m_bytes);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        string s;
        resetn  = 1'b0;
        gmii_d  = 8'h00;
        gmii_dv = 1'b0;
        gmii_er = 1'b0;
        sec     = '0;
        nsec    = '0;
        enable  = 1'b1;
        clear   = 1'b0;
        m_idle  = 0;
        model_zero();

        repeat (3) begin @(posedge clk); #1; end
        check("rst_good",     good_frames, 64'd0);
        check("rst_badpre",   bad_preamble, 64'd0);
        check("rst_bytes",    good_bytes, 64'd0);
        check("rst_ifg_min",  ifg_min, 64'hFFFF_FFFF);
        check("rst_ifg_max",  ifg_max, 64'd0);
        check("rst_done",     frame_done, 64'd0);
        check("rst_len",      frame_len, 64'd0);
        resetn = 1'b1;
        idle(5);

        // model pin: CRC-32 check value of "123456789"
        s = "123456789";
        for (int i = 0; i < 9; i++) fb[i] = s[i];
        check("model_crc_pin", crc32_of(9), 64'hCBF4_3926);

        // good 64-byte frame
        send_frame(64, 1'b0, -1);
        idle(12);
        check("t1_good_lit",  good_frames, 64'd1);
        check("t1_bytes_lit", good_bytes, 64'd64);
        check("t1_len_lit",   frame_len, 64'd64);
        check("t1_stat_lit",  frame_status, 64'd0);
        check("t1_sec_lit",   frame_sec, 64'h0000_00AB_0001);
        check("t1_nsec_lit",  frame_nsec, 64'd1007);
        check_all("t1");

        // corrupted FCS
        pulse_clear();
        send_frame(64, 1'b1, -1);
        idle(12);
        check("t2_crc_lit",   crc_err_frames, 64'd1);
        check("t2_bytes_lit", good_bytes, 64'd0);
        check("t2_stat_lit",  frame_status, 64'd1);
        check_all("t2");

        // runt
        pulse_clear();
        send_frame(56, 1'b0, -1);
        idle(12);
        check("t3_runt_lit", runt_frames, 64'd1);
        check_all("t3");

        // oversize
        pulse_clear();
        send_frame(1519, 1'b0, -1);
        idle(12);
        check("t4_over_lit", oversize_frames, 64'd1);
        check_all("t4");

        // rx error inside an otherwise good frame
        pulse_clear();
        send_frame(64, 1'b0, 10);
        idle(12);
        check("t5_rxerr_lit", rx_err_frames, 64'd1);
        check("t5_good_lit",  good_frames, 64'd0);
        check_all("t5");

        // bad preambles
        pulse_clear();
        idle(4);
        frame_start_model();
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h12, 1'b1, 1'b0);
        m_bad++;
        idle(8);
        check("t6_badpre1_lit", bad_preamble, 64'd1);
        frame_start_model();
        drive(8'hA0, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'h01, 1'b1, 1'b0);
        m_bad++;
        idle(8);
        check("t6_badpre2_lit", bad_preamble, 64'd2);
        check_all("t6");

        // inter-frame gap statistics
        pulse_clear();
        idle(5);
        send_frame(64, 1'b0, -1);
        idle(12);
        send_frame(64, 1'b0, -1);
        idle(20);
        send_frame(64, 1'b0, -1);
        idle(20);
        check("t7_ifg_last_lit", ifg_last, 64'd20);
        check("t7_ifg_min_lit",  ifg_min, 64'd12);
        check("t7_ifg_max_lit",  ifg_max, 64'd20);
        check_all("t7");
        pulse_clear();
        idle(5);
        send_frame(64, 1'b0, -1);
        idle(12);
        check("t7_min_after_clr_lit", ifg_min, 64'hFFFF_FFFF);
        check_all("t7b");

        // frames starting with enable low are ignored
        enable = 1'b0;
        send_frame(64, 1'b0, -1);
        idle(12);
        enable = 1'b1;
        check("t8_good_lit", good_frames, 64'd1);
        check_all("t8");

        // clear coincident with the end-of-frame update
        pulse_clear();
        idle(5);
        send_frame(64, 1'b0, -1);
        idle(2);
        pulse_clear();
        idle(10);
        check("t9_good_lit", good_frames, 64'd0);
        check_all("t9");

        // reset in the middle of a frame
        frame_start_model();
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(8'(i + 3), 1'b1, 1'b0);
        resetn = 1'b0;
        exp_q.delete();
        model_zero();
        idle(3);
        check("t10_rst_good",    good_frames, 64'd0);
        check("t10_rst_done",    frame_done, 64'd0);
        check("t10_rst_len",     frame_len, 64'd0);
        check("t10_rst_sec",     frame_sec, 64'd0);
        check("t10_rst_ifg_min", ifg_min, 64'hFFFF_FFFF);
        resetn = 1'b1;
        idle(5);
        send_frame(64, 1'b0, -1);
        idle(12);
        check("t10_good_lit", good_frames, 64'd1);
        check_all("t10");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
